// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte requesters: round-robin grant, message
// lock for multi-byte strings, and send_req / busy-rise / busy-fall sequencing.
module uart_tx_arbiter #(
   parameter int N              = 2,
   parameter int ACCEPT_TIMEOUT = 16,
   parameter int LOCK_TIMEOUT   = 4096
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req_valid,
   input  logic [8*N-1:0] req_data,
   input  logic [N-1:0]   req_last,
   output logic [N-1:0]   req_ready,
   output logic           tx_send_req,
   output logic [7:0]     tx_data,
   input  logic           tx_busy,
   output logic [N-1:0]   grant,
   output logic           err_timeout,
   output logic           lock_abort
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = $clog2(ACCEPT_TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACCEPT, WAIT_DONE} state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] start_reg, start_next;
   logic          locked_reg, locked_next;
   logic [IW-1:0] owner_reg, owner_next;
   logic [AW-1:0] acc_cnt_reg, acc_cnt_next;
   logic [LW-1:0] lock_cnt_reg, lock_cnt_next;
   logic [7:0]    tx_data_reg, tx_data_next;
   logic [N-1:0]  grant_reg, grant_next;
   logic          err_reg, err_next;
   logic          abort_reg, abort_next;

   logic [N-1:0]  owner_mask;
   logic [N-1:0]  cand;
   logic [7:0]    data_arr [N];
   logic          found;
   logic [IW-1:0] sel;
   logic [IW-1:0] idx;
   logic          accept;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign owner_mask[gi] = (owner_reg == IW'(gi));
         assign data_arr[gi]   = req_data[8*gi +: 8];
         assign req_ready[gi]  = accept && (sel == IW'(gi));
      end
   endgenerate

   // While locked only the owner may compete; everyone else is masked out.
   assign cand = locked_reg ? (req_valid & owner_mask) : req_valid;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start_reg) + k >= N) ? IW'(int'(start_reg) + k - N)
                                          : IW'(int'(start_reg) + k);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Reset gates the handshake so nothing is accepted while held in reset.
   assign accept = reset && (state_reg == IDLE) && !tx_busy && found;

   always_comb begin
      state_next    = state_reg;
      start_next    = start_reg;
      locked_next   = locked_reg;
      owner_next    = owner_reg;
      acc_cnt_next  = '0;
      lock_cnt_next = '0;
      tx_data_next  = tx_data_reg;
      grant_next    = grant_reg;
      err_next      = 1'b0;
      abort_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               tx_data_next = data_arr[sel];
               grant_next   = {{(N-1){1'b0}}, 1'b1} << sel;
               start_next   = (sel == IW'(N-1)) ? '0 : sel + 1'b1;
               state_next   = SEND;
               if (req_last[sel]) begin
                  locked_next = 1'b0;
               end else begin
                  locked_next = 1'b1;
                  owner_next  = sel;
               end
            end else if (locked_reg && !req_valid[owner_reg]) begin
               if (lock_cnt_reg == LW'(LOCK_TIMEOUT - 1)) begin
                  abort_next  = 1'b1;
                  locked_next = 1'b0;
                  grant_next  = '0;
               end else begin
                  lock_cnt_next = lock_cnt_reg + 1'b1;
               end
            end
         end
         SEND: state_next = WAIT_ACCEPT;
         WAIT_ACCEPT: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (acc_cnt_reg == AW'(ACCEPT_TIMEOUT - 1)) begin
               err_next    = 1'b1;
               locked_next = 1'b0;
               grant_next  = '0;
               state_next  = IDLE;
            end else begin
               acc_cnt_next = acc_cnt_reg + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         start_reg    <= '0;
         locked_reg   <= 1'b0;
         owner_reg    <= '0;
         acc_cnt_reg  <= '0;
         lock_cnt_reg <= '0;
         tx_data_reg  <= '0;
         grant_reg    <= '0;
         err_reg      <= 1'b0;
         abort_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         start_reg    <= start_next;
         locked_reg   <= locked_next;
         owner_reg    <= owner_next;
         acc_cnt_reg  <= acc_cnt_next;
         lock_cnt_reg <= lock_cnt_next;
         tx_data_reg  <= tx_data_next;
         grant_reg    <= grant_next;
         err_reg      <= err_next;
         abort_reg    <= abort_next;
      end
   end

   assign tx_send_req = (state_reg == SEND);
   assign tx_data     = tx_data_reg;
   assign grant       = grant_reg;
   assign err_timeout = err_reg;
   assign lock_abort  = abort_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters and a scripted transmitter, checked every
// cycle against a timestamp-based arbitration model plus a few literal expectations.
module tb_uart_tx_arbiter;
   localparam int N  = 3;
   localparam int AT = 16;
   localparam int LT = 20;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_send_req;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [N-1:0]   grant;
   logic           err_timeout;
   logic           lock_abort;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N(N), .ACCEPT_TIMEOUT(AT), .LOCK_TIMEOUT(LT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_send_req(tx_send_req),
      .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant),
      .err_timeout(err_timeout), .lock_abort(lock_abort)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [8:0] rq [N][$];       // per requester: {last, data}
   int gate_pct = 100;

   int tx_delay = 2, tx_hold = 10, rise_at = -1000;
   bit tx_never = 0, tx_rand = 0;

   // reference model: arbiter free/locked status as event timestamps
   bit           m_free, m_locked;
   int           m_owner, m_start, m_lcnt;
   logic [7:0]   m_data;
   logic [N-1:0] m_grant;
   int           m_send_at, m_wa_start, m_busy_seen, m_err_at, m_abort_at;

   int order[$];
   int exp_q[$];
   int send_cyc = -1, err_cyc = -1, abort_cyc = -1, fall_cyc = -1, acc_cyc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_free = 1; m_locked = 0; m_owner = 0; m_start = 0; m_lcnt = 0;
      m_data = '0; m_grant = '0; m_send_at = -1; m_wa_start = -1;
      m_busy_seen = -1; m_err_at = -1; m_abort_at = -1; rise_at = -1000;
   endtask

   task automatic observe();
      logic [N-1:0] exp_ready;
      logic [N-1:0] cand;
      bit found;
      int sel, idx;
      exp_ready = '0; found = 0; sel = 0;
      if (!reset) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_tx_send_req", 32'(tx_send_req), 32'd0);
         chk("rst_tx_data", 32'(tx_data), 32'd0);
         chk("rst_grant", 32'(grant), 32'd0);
         chk("rst_err_timeout", 32'(err_timeout), 32'd0);
         chk("rst_lock_abort", 32'(lock_abort), 32'd0);
         model_reset();
         return;
      end
      cand = req_valid;
      if (m_locked) begin
         cand = '0;
         cand[m_owner] = req_valid[m_owner];
      end
      if (m_free && !tx_busy) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_start + k) % N;
            if (!found && cand[idx]) begin found = 1; sel = idx; end
         end
      end
      if (found) exp_ready[sel] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("tx_send_req", 32'(tx_send_req), 32'(cyc == m_send_at));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("grant", 32'(grant), 32'(m_grant));
      chk("err_timeout", 32'(err_timeout), 32'(cyc == m_err_at));
      chk("lock_abort", 32'(lock_abort), 32'(cyc == m_abort_at));

      if (err_timeout) err_cyc = cyc;
      if (lock_abort) abort_cyc = cyc;
      if (tx_send_req) begin
         send_cyc = cyc;
         if (tx_rand) begin
            tx_delay = $urandom_range(1, 3);
            tx_hold  = $urandom_range(1, 4);
            tx_never = ($urandom_range(7) == 0);
         end
         rise_at = tx_never ? (1 << 30) : cyc + tx_delay;
      end
      for (int i = 0; i < N; i++) begin
         if (req_ready[i] && req_valid[i] && rq[i].size() > 0) begin
            order.push_back(i);
            void'(rq[i].pop_front());
            acc_cyc = cyc;
         end
      end

      if (found) begin
         m_data = req_data[8*sel +: 8];
         m_grant = '0; m_grant[sel] = 1'b1;
         m_start = (sel + 1) % N;
         if (req_last[sel]) m_locked = 0;
         else begin m_locked = 1; m_owner = sel; end
         m_free = 0; m_send_at = cyc + 1; m_wa_start = cyc + 2;
         m_busy_seen = -1; m_lcnt = 0;
      end else if (m_free) begin
         if (m_locked && !req_valid[m_owner]) begin
            m_lcnt++;
            if (m_lcnt == LT) begin
               m_abort_at = cyc + 1; m_locked = 0; m_grant = '0; m_lcnt = 0;
            end
         end else m_lcnt = 0;
      end else begin
         m_lcnt = 0;
         if (cyc >= m_wa_start) begin
            if (m_busy_seen < 0) begin
               if (tx_busy) m_busy_seen = cyc;
               else if (cyc - m_wa_start == AT - 1) begin
                  m_err_at = cyc + 1; m_free = 1; m_locked = 0; m_grant = '0;
               end
            end else if (!tx_busy) begin
               m_free = 1; fall_cyc = cyc;
            end
         end
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0 && $urandom_range(99) < gate_pct) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i] = rq[i][0][8];
         end else begin
            req_valid[i] = 1'b0;
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i] = 1'($urandom);
         end
      end
      tx_busy = (cyc >= rise_at) && (cyc < rise_at + tx_hold);
   endtask

   task automatic tick();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      cyc++;
      apply();
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 0;
      return 1;
   endfunction

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (!(m_free && all_empty() && !tx_busy) && n < budget) begin tick(); n++; end
      tick();
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL %s: drain budget %0d cycles expired", name, budget);
      end
   endtask

   task automatic check_order(input string name);
      chk({name, "_count"}, 32'(order.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < order.size(); i++)
         chk({name, "_order"}, 32'(order[i]), 32'(exp_q[i]));
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      tick(); tick();
      reset = 1'b1;
   endtask

   initial begin
      int n;
      reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
      model_reset();
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // single byte 0x41, busy 2 cycles after pulse for 10 cycles
      rq[0].push_back({1'b1, 8'h41});
      drain("t1", 60);
      $display("t1 single byte: order size %0d tx_data %0h", order.size(), tx_data);
      exp_q = '{0};
      check_order("t1");
      chk("t1_latency", 32'(send_cyc - acc_cyc), 32'd1);
      chk("t1_tx_data_hold", 32'(tx_data), 32'h41);

      // two requesters from reset alternate
      reset_pulse();
      order.delete(); tx_delay = 1; tx_hold = 2;
      rq[0].push_back({1'b1, 8'h01}); rq[0].push_back({1'b1, 8'h02});
      rq[1].push_back({1'b1, 8'h11}); rq[1].push_back({1'b1, 8'h12});
      drain("t2", 80);
      $display("t2 round robin: %0d bytes", order.size());
      exp_q = '{0, 1, 0, 1};
      check_order("t2");

      // locked "AB" from req1 stays contiguous while req0 waits
      order.delete();
      rq[0].push_back({1'b1, 8'h20});
      drain("t3a", 40);
      rq[1].push_back({1'b0, 8'h41}); rq[1].push_back({1'b1, 8'h42});
      rq[0].push_back({1'b1, 8'h21}); rq[0].push_back({1'b1, 8'h22});
      drain("t3", 100);
      $display("t3 lock message: %0d bytes", order.size());
      exp_q = '{0, 1, 1, 0, 0};
      check_order("t3");

      // transmitter never accepts a locked byte
      order.delete(); err_cyc = -1; tx_never = 1;
      rq[0].push_back({1'b0, 8'h10});
      n = 0;
      while (order.size() == 0 && n < 20) begin tick(); n++; end
      rq[1].push_back({1'b1, 8'h30}); rq[0].push_back({1'b1, 8'h11});
      n = 0;
      while (err_cyc < 0 && n < 60) begin tick(); n++; end
      tx_never = 0;
      chk("t4_err_seen", 32'(err_cyc >= 0), 32'd1);
      chk("t4_err_delay", 32'(err_cyc - send_cyc), 32'(AT + 1));
      drain("t4", 80);
      $display("t4 accept timeout: err at cycle %0d, %0d bytes", err_cyc, order.size());
      exp_q = '{0, 1, 0};
      check_order("t4");

      // lock owner goes quiet: lock_abort then req1 served
      order.delete(); abort_cyc = -1;
      rq[0].push_back({1'b0, 8'h50});
      n = 0;
      while (order.size() == 0 && n < 20) begin tick(); n++; end
      rq[1].push_back({1'b1, 8'h51});
      n = 0;
      while (abort_cyc < 0 && n < 100) begin tick(); n++; end
      chk("t5_abort_seen", 32'(abort_cyc >= 0), 32'd1);
      chk("t5_abort_delay", 32'(abort_cyc - fall_cyc), 32'(LT + 1));
      drain("t5", 60);
      $display("t5 lock abort at cycle %0d, %0d bytes", abort_cyc, order.size());
      exp_q = '{0, 1};
      check_order("t5");

      // reset while the transmitter is busy
      tx_delay = 1; tx_hold = 10;
      rq[1].push_back({1'b1, 8'h55});
      n = 0;
      while (!(!m_free && m_busy_seen >= 0 && cyc > m_busy_seen) && n < 40) begin tick(); n++; end
      reset_pulse();
      order.delete(); tx_hold = 2;
      rq[0].push_back({1'b1, 8'h77}); rq[1].push_back({1'b1, 8'h78});
      drain("t6", 60);
      $display("t6 reset mid-transfer: %0d bytes after release", order.size());
      exp_q = '{0, 1};
      check_order("t6");

      // randomized traffic
      order.delete(); tx_rand = 1; gate_pct = 75;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() == 0 && $urandom_range(3) == 0) begin
               int len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++)
                  rq[i].push_back({1'(b == len - 1), 8'($urandom)});
            end
         end
         tick();
      end
      tx_rand = 0; tx_never = 0; gate_pct = 100; tx_delay = 1; tx_hold = 2;
      drain("rand", 400);
      $display("random phase: %0d bytes accepted", order.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
